// File: rtl/light_pkg.sv
// light_pkg: light codes and lane engine states shared by the intersection model
package light_pkg;
  typedef enum logic [1:0] {GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10, ILLEGAL = 2'b11} light_t;
  typedef enum logic {IDLE, SERVE} lane_state_t;
endpackage

// File: rtl/lane_queue.sv
// lane_queue: per-street vehicle queue released one vehicle per DEPART_CYCLES green cycles
module lane_queue
  import light_pkg::*;
#(
  parameter int CNT_W         = 3,
  parameter int DEPART_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arrive,
  input  light_t           light,
  output logic [CNT_W-1:0] q,
  output logic             sensor,
  output logic             depart,
  output logic             drop
);
  localparam int TW = DEPART_CYCLES > 1 ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_FULL = '1;
  lane_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [CNT_W-1:0] q_q, q_d;
  logic dep_q, dep_d, drop_q, drop_d, green, due;
  always_comb begin
    green   = light == GREEN;
    due     = state_q == SERVE && green && t_q == T_LAST;
    dep_d   = due && q_q != '0;
    drop_d  = arrive && !dep_d && q_q == Q_FULL;
    state_d = green ? SERVE : IDLE;
    t_d     = (state_q != SERVE || !green) ? '0 : due ? (dep_d ? '0 : t_q) : t_q + 1'b1;
    q_d     = drop_d ? q_q : q_q + CNT_W'(arrive) - CNT_W'(dep_d);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      q_q     <= '0;
      dep_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      q_q     <= q_d;
      dep_q   <= dep_d;
      drop_q  <= drop_d;
    end
  end
  assign q      = q_q;
  assign sensor = q_q != '0;
  assign depart = dep_q;
  assign drop   = drop_q;
endmodule

// File: rtl/intersection_model.sv
// intersection_model: two-street traffic plant with sensors and a sticky unsafe-light detector
module intersection_model
  import light_pkg::*;
#(
  parameter int CNT_W         = 3,
  parameter int DEPART_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arrive_a,
  input  logic             arrive_b,
  input  logic             la1,
  input  logic             la0,
  input  logic             lb1,
  input  logic             lb0,
  output logic             sa,
  output logic             sb,
  output logic [CNT_W-1:0] qa,
  output logic [CNT_W-1:0] qb,
  output logic             depart_a,
  output logic             depart_b,
  output logic             drop_a,
  output logic             drop_b,
  output logic             violation
);
  light_t la, lb;
  logic viol_q, viol_d;
  assign la = light_t'({la1, la0});
  assign lb = light_t'({lb1, lb0});
  lane_queue #(.CNT_W(CNT_W), .DEPART_CYCLES(DEPART_CYCLES)) u_lane_a (
    .clk(clk), .reset(reset), .arrive(arrive_a), .light(la),
    .q(qa), .sensor(sa), .depart(depart_a), .drop(drop_a)
  );
  lane_queue #(.CNT_W(CNT_W), .DEPART_CYCLES(DEPART_CYCLES)) u_lane_b (
    .clk(clk), .reset(reset), .arrive(arrive_b), .light(lb),
    .q(qb), .sensor(sb), .depart(depart_b), .drop(drop_b)
  );
  always_comb viol_d = viol_q || (la != RED && lb != RED) || la == ILLEGAL || lb == ILLEGAL;
  always_ff @(posedge clk) viol_q <= reset ? 1'b0 : viol_d;
  assign violation = viol_q;
endmodule
